// File: rtl/ok_axi4lite_reg_slave.sv
// AXI4-Lite register bank responder on the okClkIn domain.
// Independent AW/W capture, one outstanding write, single-beat reads; out-of-range accesses return SLVERR.
module ok_axi4lite_reg_slave #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                           okClkIn,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned STRB_W      = DATA_WIDTH / 8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_COMMIT, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_RESP} rstate_t;

  wstate_t wstate, wstate_nxt;
  rstate_t rstate, rstate_nxt;

  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic        aw_held, w_held, commit;
  logic        aw_hs, w_hs, ar_hs;
  logic [31:0] aw_idx, ar_idx;
  logic        aw_in_range, ar_in_range;
  logic [DATA_WIDTH-1:0] rd_mux;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid  & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  assign aw_idx      = 32'(awaddr_q[ADDR_WIDTH-1:2]);
  assign ar_idx      = 32'(s_axi_araddr[ADDR_WIDTH-1:2]);
  assign aw_in_range = (aw_idx < NUM_REGS);
  assign ar_in_range = (ar_idx < NUM_REGS);

  // State registers
  always_ff @(posedge okClkIn or posedge rst) begin
    if (rst) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
    end else begin
      wstate <= wstate_nxt;
      rstate <= rstate_nxt;
    end
  end

  always_comb begin
    wstate_nxt = wstate;
    unique case (wstate)
      W_IDLE: begin
        if (aw_hs && w_hs) wstate_nxt = W_COMMIT;
        else if (aw_hs)    wstate_nxt = W_HAVE_A;
        else if (w_hs)     wstate_nxt = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)  wstate_nxt = W_COMMIT;
      W_HAVE_D: if (aw_hs) wstate_nxt = W_COMMIT;
      W_COMMIT:            wstate_nxt = W_RESP;
      W_RESP:   if (s_axi_bready) wstate_nxt = W_IDLE;
      default:             wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_nxt = rstate;
    unique case (rstate)
      R_IDLE:  if (ar_hs)        rstate_nxt = R_RESP;
      R_RESP:  if (s_axi_rready) rstate_nxt = R_IDLE;
      default:                   rstate_nxt = R_IDLE;
    endcase
  end

  // Handshake outputs are decoded from state and rst only.
  always_comb begin
    aw_held       = (wstate == W_HAVE_A) || (wstate == W_COMMIT);
    w_held        = (wstate == W_HAVE_D) || (wstate == W_COMMIT);
    commit        = aw_held & w_held;
    s_axi_bvalid  = (wstate == W_RESP);
    s_axi_awready = ~rst & ~aw_held & ~s_axi_bvalid;
    s_axi_wready  = ~rst & ~w_held  & ~s_axi_bvalid;
    s_axi_rvalid  = (rstate == R_RESP);
    s_axi_arready = ~rst & ~s_axi_rvalid;
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (ar_idx == i) rd_mux = regs[i];
  end

  always_comb begin
    regs_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      regs_out[DATA_WIDTH*i +: DATA_WIDTH] = regs[i];
  end

  // A read sampled on the commit edge sees the pre-write register value.
  always_ff @(posedge okClkIn or posedge rst) begin
    if (rst) begin
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wr_pulse    <= '0;
      s_axi_bresp <= RESP_OKAY;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_pulse <= '0;
      if (aw_hs) awaddr_q <= s_axi_awaddr;
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (commit) begin
        s_axi_bresp <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (aw_in_range && aw_idx == i) begin
            wr_pulse[i] <= 1'b1;
            for (int unsigned k = 0; k < STRB_W; k++)
              if (wstrb_q[k]) regs[i][8*k +: 8] <= wdata_q[8*k +: 8];
          end
        end
      end
      if (ar_hs) begin
        s_axi_rdata <= ar_in_range ? rd_mux : '0;
        s_axi_rresp <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_ok_axi4lite_reg_slave.sv
// Scoreboard bench for ok_axi4lite_reg_slave: drivers queue expected B/R responses,
// a negedge monitor pops and compares them at each B/R handshake.
module tb_ok_axi4lite_reg_slave;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [11:0]  s_axi_awaddr = '0;
  logic         s_axi_awvalid = 1'b0;
  logic         s_axi_awready;
  logic [31:0]  s_axi_wdata = '0;
  logic [3:0]   s_axi_wstrb = '0;
  logic         s_axi_wvalid = 1'b0;
  logic         s_axi_wready;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid;
  logic         s_axi_bready = 1'b1;
  logic [11:0]  s_axi_araddr = '0;
  logic         s_axi_arvalid = 1'b0;
  logic         s_axi_arready;
  logic [31:0]  s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rvalid;
  logic         s_axi_rready = 1'b1;
  logic [511:0] regs_out;
  logic [15:0]  wr_pulse;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic [1:0] bq[$];
  rexp_t      rq[$];
  int tests = 0;
  int fails = 0;
  logic [511:0] snap;

  ok_axi4lite_reg_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .okClkIn(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .regs_out(regs_out), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: handshake timeout, got no ready expected ready", name);
  endtask

  // Monitor: one comparison per B or R handshake
  always @(negedge clk) begin
    if (!rst && s_axi_bvalid && s_axi_bready) begin
      if (bq.size() == 0) check("b_unexpected", 1, 0);
      else check("bresp", s_axi_bresp, bq.pop_front());
    end
    if (!rst && s_axi_rvalid && s_axi_rready) begin
      if (rq.size() == 0) check("r_unexpected", 1, 0);
      else begin
        rexp_t e;
        e = rq.pop_front();
        check("rdata", s_axi_rdata, e.data);
        check("rresp", s_axi_rresp, e.resp);
      end
    end
  end

  // Drivers: all return at posedge+1 after their handshake edge.
  task automatic send_aw(input logic [11:0] a);
    bit got = 0;
    s_axi_awaddr = a;
    s_axi_awvalid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); got = s_axi_awready;
      @(posedge clk); #1;
    end
    s_axi_awvalid = 1'b0;
    if (!got) timeout_fail("aw_timeout");
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit got = 0;
    s_axi_wdata = d;
    s_axi_wstrb = s;
    s_axi_wvalid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); got = s_axi_wready;
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0;
    if (!got) timeout_fail("w_timeout");
  endtask

  task automatic send_ar(input logic [11:0] a);
    bit got = 0;
    s_axi_araddr = a;
    s_axi_arvalid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); got = s_axi_arready;
      @(posedge clk); #1;
    end
    s_axi_arvalid = 1'b0;
    if (!got) timeout_fail("ar_timeout");
  endtask

  task automatic write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [1:0] resp);
    bq.push_back(resp);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  task automatic read(input logic [11:0] a, input logic [31:0] d, input logic [1:0] resp);
    rq.push_back('{data: d, resp: resp});
    send_ar(a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_readys", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    check("rst_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
    check("rst_resp_data", {s_axi_bresp, s_axi_rresp, s_axi_rdata}, '0);
    check("rst_regs", regs_out, '0);
    check("rst_pulse", wr_pulse, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_readys", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    @(posedge clk); #1;

    // Same-cycle AW/W write, check commit latency and pulse width
    write(12'h004, 32'hDEADBEEF, 4'hF, 2'b00);
    @(negedge clk);
    check("bvalid_not_early", s_axi_bvalid, 1'b0);
    @(posedge clk); #1;
    check("bvalid_after_commit", s_axi_bvalid, 1'b1);
    check("reg1_value", regs_out[63:32], 32'hDEADBEEF);
    check("pulse_reg1", wr_pulse, 16'h0002);
    @(posedge clk); #1;
    check("pulse_one_cycle", wr_pulse, 16'h0000);
    read(12'h004, 32'hDEADBEEF, 2'b00);

    // W first, AW three cycles later, partial strobes
    write(12'h008, 32'hAAAAAAAA, 4'hF, 2'b00);
    bq.push_back(2'b00);
    send_w(32'h11223344, 4'h5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wready_held_low", s_axi_wready, 1'b0);
      @(posedge clk); #1;
    end
    send_aw(12'h008);
    @(posedge clk); #1;
    check("reg2_strobed", regs_out[95:64], 32'hAA22AA44);
    read(12'h008, 32'hAA22AA44, 2'b00);

    // Out-of-range write and read
    @(posedge clk); #1;
    snap = regs_out;
    write(12'h040, 32'h12345678, 4'hF, 2'b10);
    @(posedge clk); #1;
    check("oor_no_pulse", wr_pulse, 16'h0000);
    check("oor_regs_same", regs_out, snap);
    read(12'h040, 32'h0, 2'b10);

    // Back-pressure on B: response held, AW/W blocked
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    write(12'h00C, 32'h00000077, 4'hF, 2'b00);
    @(posedge clk); #1;
    s_axi_awaddr = 12'h010;
    s_axi_awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("b_held", {s_axi_bvalid, s_axi_bresp}, 3'b100);
      check("aw_w_blocked", {s_axi_awready, s_axi_wready}, 2'b00);
      @(posedge clk); #1;
    end
    s_axi_bready = 1'b1;
    write(12'h010, 32'h00000099, 4'hF, 2'b00);
    @(posedge clk); #1;
    read(12'h00C, 32'h00000077, 2'b00);
    read(12'h010, 32'h00000099, 2'b00);

    // Read/commit collision on register 2
    write(12'h008, 32'h00000003, 4'hF, 2'b00);
    bq.push_back(2'b00);
    send_w(32'h00000005, 4'hF);
    send_aw(12'h008);
    read(12'h008, 32'h00000003, 2'b00);
    read(12'h008, 32'h00000005, 2'b00);

    // Reset with AW held and R pending
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    send_ar(12'h004);
    send_aw(12'h014);
    @(negedge clk);
    check("pre_rst_state", {s_axi_rvalid, s_axi_bvalid, s_axi_awready}, 3'b100);
    rst = 1'b1;
    #2;
    check("mid_rst_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
    check("mid_rst_readys", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    check("mid_rst_rdata", {s_axi_rdata, s_axi_rresp, s_axi_bresp}, '0);
    check("mid_rst_regs", regs_out, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    s_axi_rready = 1'b1;
    send_w(32'hFFFFFFFF, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_commit_w_only", {s_axi_bvalid, wr_pulse}, '0);
      @(posedge clk); #1;
    end
    check("no_commit_regs", regs_out, '0);

    repeat (3) @(posedge clk);
    #1;
    check("bq_drained", bq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
